alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_iter_unit.sv | 63 ++++++
 rtl/alu_seq.sv | 93 +++++++++
 tb/tb_alu_seq.sv | 100 ++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared word width, opcodes and FSM state encoding for alu_seq
// Provides `WORD (operand range), WORD_W, OP_* opcodes and state_t.
`ifndef WORD
`define WORD [15:0]
`endif
package alu_seq_pkg;
  typedef logic `WORD word_t;
  localparam int WORD_W = $bits(word_t);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle shifter and shift-add multiplier datapath
// Ports: clk, reset (async, active-high); load/step enables; op, x, shamt
// (and y when ALU_MUL_EN is defined) sampled on load; acc_next is the value
// acc takes on the current step; last is high on the final step.
// Macro ALU_MUL_EN builds the mcand/mplier registers and the multiply step.
module alu_iter_unit import alu_seq_pkg::*; #(
  parameter int WIDTH   = WORD_W,
  parameter int SHAMT_W = $clog2(WORD_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0]   y,
`endif
  output logic [WIDTH-1:0]   acc_next,
  output logic               last
);
  localparam int CNT_W = SHAMT_W + 1;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == CNT_W'(1);
  assign op_d = load ? op : op_q;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  always_comb begin
    acc_next = op_q == OP_SHL ? acc_q << 1 : op_q == OP_SHR ? acc_q >> 1 : acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = load ? (op == OP_MUL ? '0 : x) : step ? acc_next : acc_q;
    cnt_d    = load ? (op == OP_MUL ? CNT_W'(WIDTH) : {1'b0, shamt}) : step ? cnt_q - CNT_W'(1) : cnt_q;
    mcand_d  = load ? x : step ? mcand_q << 1 : mcand_q;
    mplier_d = load ? y : step ? mplier_q >> 1 : mplier_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
`else
  always_comb begin
    acc_next = op_q == OP_SHL ? acc_q << 1 : acc_q >> 1;
    acc_d    = load ? x : step ? acc_next : acc_q;
    cnt_d    = load ? {1'b0, shamt} : step ? cnt_q - CNT_W'(1) : cnt_q;
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle valid/ready ALU (single-cycle logic, iterative shift/multiply)
// Ports: clk, reset (async, active-high); request in_valid/in_ready with
// ALUop, X, Y; response out_valid/out_ready with result z.
// Macro ALU_MUL_EN enables the 16-step multiplier; otherwise opcode 111
// completes in one cycle with z=0.
module alu_seq import alu_seq_pkg::*; #(
  parameter int WIDTH   = WORD_W,
  parameter int SHAMT_W = $clog2(WORD_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d, alu_res, iter_next;
  logic             out_valid_q, out_valid_d, accept, is_shift, is_iter;
  logic             iter_load, iter_step, iter_last;
  assign in_ready  = state_q == IDLE && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign is_shift  = ALUop == OP_SHL || ALUop == OP_SHR;
`ifdef ALU_MUL_EN
  assign is_iter = (is_shift && |Y[SHAMT_W-1:0]) || ALUop == OP_MUL;
`else
  assign is_iter = is_shift && |Y[SHAMT_W-1:0];
`endif
  assign alu_res = ALUop == OP_ADD ? X + Y :
                   ALUop == OP_SUB ? X - Y :
                   ALUop == OP_AND ? X & Y :
                   ALUop == OP_OR  ? X | Y :
                   ALUop == OP_XOR ? X ^ Y :
                   is_shift        ? X : '0;
  alu_iter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (iter_load),
    .step     (iter_step),
    .op       (ALUop),
    .x        (X),
    .shamt    (Y[SHAMT_W-1:0]),
`ifdef ALU_MUL_EN
    .y        (Y),
`endif
    .acc_next (iter_next),
    .last     (iter_last)
  );
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    iter_load   = 1'b0;
    iter_step   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        iter_load   = is_iter;
        state_d     = is_iter ? BUSY : DONE;
        z_d         = is_iter ? z_q : alu_res;
        out_valid_d = !is_iter;
      end
      BUSY: begin
        iter_step = 1'b1;
        if (iter_last) begin
          z_d         = iter_next;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
module tb_alu_seq;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [2:0]  ALUop = 3'b000;
  logic [15:0] X = '0, Y = '0, z;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop     (ALUop),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ez, input int elat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    ALUop = op; X = a; Y = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0; X = 16'hDEAD; Y = 16'hBEEF; ALUop = 3'b011;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".z"}, 32'(z), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_z"}, 32'(z), 32'(ez));
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".valid_post"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.z", 32'(z), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 chk("rst.in_ready_rel", 32'(in_ready), 32'd1);
    run_op("add", 3'b000, 16'h0003, 16'h0004, 16'h0007, 1, 0);
    run_op("sub", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
    run_op("xor", 3'b100, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1, 0);
    run_op("or", 3'b011, 16'h1200, 16'h0034, 16'h1234, 1, 0);
    run_op("shl3", 3'b101, 16'h0001, 16'h0013, 16'h0008, 4, 0);
    run_op("shr0", 3'b110, 16'h8000, 16'h0000, 16'h8000, 1, 0);
    run_op("shr15", 3'b110, 16'h8000, 16'h00FF, 16'h0001, 16, 0);
    run_op("shl_k1", 3'b101, 16'hC001, 16'hFFF1, 16'h8002, 2, 0);
    run_op("mul3x5", 3'b111, 16'h0003, 16'h0005, MUL_EN ? 16'h000F : 16'h0000, MUL_EN ? 17 : 1, 0);
    run_op("mul_wrap", 3'b111, 16'h0100, 16'h0100, 16'h0000, MUL_EN ? 17 : 1, 0);
    run_op("mul_big", 3'b111, 16'h1234, 16'h0003, MUL_EN ? 16'h369C : 16'h0000, MUL_EN ? 17 : 1, 0);
    run_op("and_bp", 3'b010, 16'h00FF, 16'h0F0F, 16'h000F, 1, 5);
    @(negedge clk);
    ALUop = 3'b111; X = 16'h0003; Y = 16'h0005; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.z", 32'(z), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("midrst.in_ready_hold", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 chk("midrst.in_ready_rel", 32'(in_ready), 32'd1);
    run_op("add_after_rst", 3'b000, 16'h0001, 16'h0001, 16'h0002, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
